// File: rtl/cosine_distance_unit.sv
// cosine_distance_unit
// Computes cos(x) by a truncated Taylor series and scales it by a velocity,
// giving distance = v * cos(x). All arithmetic is signed fixed point with
// FRAC fraction bits, and every multiply or add saturates. Any clamp during
// a run sets the sticky sat flag.
//
// Handshake: start is a request that is honoured only while the unit is idle
// (busy low). On the accepting edge the operands are captured, busy rises and
// done/sat clear. busy stays high for exactly 2*TERMS cycles. On the edge
// where it falls, done rises together with cos_out, distance and sat. done is
// a level and stays high until the next accepted start. start while busy is
// ignored.
//
// Ports:
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   run request, sampled only in IDLE
//   x_in      in   W-bit signed angle in radians, FRAC fraction bits
//   v_in      in   W-bit signed velocity
//   busy      out  computation in flight
//   done      out  result valid, held until the next accepted start
//   cos_out   out  final series sum
//   distance  out  v * cos
//   sat       out  sticky saturation flag for the current/last run
//   dbg_state out  current FSM state, for observation only

module cosine_distance_unit #(
    parameter int W     = 16,
    parameter int FRAC  = 11,
    parameter int TERMS = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] v_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] cos_out,
    output logic [W-1:0] distance,
    output logic         sat,
    output logic [2:0]   dbg_state
);

    generate
        if (TERMS < 1 || TERMS > 8) begin : g_bad_terms
            $fatal(1, "cosine_distance_unit: TERMS must be in 1..8");
        end
        if (FRAC >= W) begin : g_bad_frac
            $fatal(1, "cosine_distance_unit: FRAC must be smaller than W");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        DIST = 3'd4
    } state_t;

    localparam logic [W-1:0] ONE    = W'(1) << FRAC;
    localparam logic [W-1:0] MAX_W  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_W  = {1'b1, {(W-1){1'b0}}};
    // Index of the last series term; the MUL1/MUL2 loop stops after it.
    localparam logic [3:0]   LAST_K = 4'(TERMS - 1);

    // round(2^FRAC / ((2k-1)(2k))) using integer round-half-up.
    function automatic logic [W-1:0] recip(input int k);
        longint d;
        longint num;
        d   = longint'((2 * k - 1) * (2 * k));
        num = (longint'(1) << (FRAC + 1)) + d;
        return W'(num / (2 * d));
    endfunction

    // Result is {clamped, value}.
    function automatic logic [W:0] sat_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] prod;
        logic signed [2*W-1:0] shr;
        prod = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        shr  = prod >>> FRAC;
        // In range only if the upper W+1 bits are a pure sign extension.
        if (shr[2*W-1:W-1] == {(W+1){1'b0}} || shr[2*W-1:W-1] == {(W+1){1'b1}}) begin
            return {1'b0, shr[W-1:0]};
        end
        return {1'b1, (shr[2*W-1] ? MIN_W : MAX_W)};
    endfunction

    function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) begin
            return {1'b1, (s[W] ? MIN_W : MAX_W)};
        end
        return {1'b0, s[W-1:0]};
    endfunction

    function automatic logic [W:0] sat_neg(input logic [W-1:0] a);
        if (a == MIN_W) begin
            return {1'b1, MAX_W};
        end
        return {1'b0, W'(-a)};
    endfunction

    state_t       state_q, state_d;
    logic [W-1:0] x_q, x_d, v_q, v_d, x2_q, x2_d;
    logic [W-1:0] term_q, term_d, expr_q, expr_d, p_q, p_d;
    logic [W-1:0] cos_q, cos_d, dist_q, dist_d;
    logic [3:0]   k_q, k_d;
    logic         busy_q, busy_d, done_q, done_d, sat_q, sat_d;

    logic [W-1:0] r_tab [8];
    logic [W:0]   r_mul, r_neg, r_add;

    // Constant coefficient table; entry 0 is never selected.
    always_comb begin
        r_tab[0] = '0;
        for (int i = 1; i < 8; i++) begin
            r_tab[i] = recip(i);
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        v_d     = v_q;
        x2_d    = x2_q;
        term_d  = term_q;
        expr_d  = expr_q;
        p_d     = p_q;
        cos_d   = cos_q;
        dist_d  = dist_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sat_d   = sat_q;
        r_mul   = '0;
        r_neg   = '0;
        r_add   = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    x_d     = x_in;
                    v_d     = v_in;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    sat_d   = 1'b0;
                end
            end
            LOAD: begin
                r_mul   = sat_mul(x_q, x_q);
                x2_d    = r_mul[W-1:0];
                sat_d   = sat_q | r_mul[W];
                term_d  = ONE;
                expr_d  = ONE;
                k_d     = 4'd1;
                state_d = (TERMS > 1) ? MUL1 : DIST;
            end
            MUL1: begin
                r_mul   = sat_mul(term_q, x2_q);
                p_d     = r_mul[W-1:0];
                sat_d   = sat_q | r_mul[W];
                state_d = MUL2;
            end
            MUL2: begin
                r_mul   = sat_mul(p_q, r_tab[k_q[2:0]]);
                r_neg   = sat_neg(r_mul[W-1:0]);
                r_add   = sat_add(expr_q, r_neg[W-1:0]);
                term_d  = r_neg[W-1:0];
                expr_d  = r_add[W-1:0];
                sat_d   = sat_q | r_mul[W] | r_neg[W] | r_add[W];
                k_d     = k_q + 4'd1;
                state_d = (k_q < LAST_K) ? MUL1 : DIST;
            end
            DIST: begin
                r_mul   = sat_mul(v_q, expr_q);
                dist_d  = r_mul[W-1:0];
                cos_d   = expr_q;
                sat_d   = sat_q | r_mul[W];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            v_q     <= '0;
            x2_q    <= '0;
            term_q  <= '0;
            expr_q  <= '0;
            p_q     <= '0;
            cos_q   <= '0;
            dist_q  <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            v_q     <= v_d;
            x2_q    <= x2_d;
            term_q  <= term_d;
            expr_q  <= expr_d;
            p_q     <= p_d;
            cos_q   <= cos_d;
            dist_q  <= dist_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cos_out   = cos_q;
    assign distance  = dist_q;
    assign sat       = sat_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cosine_distance_unit.sv
// Bench for cosine_distance_unit. Three instances share the stimulus with
// TERMS = 1, 4 and 8. A behavioural model (plain integer series evaluation
// plus a latency counter) predicts every output, and a negedge process
// compares all instances against it each cycle.

module tb_cosine_distance_unit;

    localparam int W    = 16;
    localparam int FRAC = 11;

    int tv [3] = '{1, 4, 8};
    int rk [7] = '{1024, 171, 68, 37, 23, 16, 11};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic [W-1:0] x_in, v_in;

    always #5 clk = ~clk;

    logic         busy_w [3];
    logic         done_w [3];
    logic         sat_w  [3];
    logic [W-1:0] cos_w  [3];
    logic [W-1:0] dist_w [3];
    logic [2:0]   dbg_w  [3];

    cosine_distance_unit #(.W(W), .FRAC(FRAC), .TERMS(1)) dut_t1 (
        .clk(clk), .reset_n(reset_n), .start(start), .x_in(x_in), .v_in(v_in),
        .busy(busy_w[0]), .done(done_w[0]), .cos_out(cos_w[0]), .distance(dist_w[0]),
        .sat(sat_w[0]), .dbg_state(dbg_w[0])
    );
    cosine_distance_unit #(.W(W), .FRAC(FRAC), .TERMS(4)) dut_t4 (
        .clk(clk), .reset_n(reset_n), .start(start), .x_in(x_in), .v_in(v_in),
        .busy(busy_w[1]), .done(done_w[1]), .cos_out(cos_w[1]), .distance(dist_w[1]),
        .sat(sat_w[1]), .dbg_state(dbg_w[1])
    );
    cosine_distance_unit #(.W(W), .FRAC(FRAC), .TERMS(8)) dut_t8 (
        .clk(clk), .reset_n(reset_n), .start(start), .x_in(x_in), .v_in(v_in),
        .busy(busy_w[2]), .done(done_w[2]), .cos_out(cos_w[2]), .distance(dist_w[2]),
        .sat(sat_w[2]), .dbg_state(dbg_w[2])
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] @%0t: got %h, expected %h", name, idx, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint clamp(input longint a, inout bit s);
        if (a > 32767) begin s = 1'b1; return 32767; end
        if (a < -32768) begin s = 1'b1; return -32768; end
        return a;
    endfunction

    function automatic longint fmul(input longint a, input longint b, inout bit s);
        return clamp((a * b) >>> FRAC, s);
    endfunction

    task automatic ref_cos(input int terms, input logic [W-1:0] x, input logic [W-1:0] v,
                           output logic [W-1:0] c, output logic [W-1:0] d, output bit s);
        longint xs, vs, x2, term, expr, p;
        bit sf;
        sf   = 1'b0;
        xs   = longint'($signed(x));
        vs   = longint'($signed(v));
        x2   = fmul(xs, xs, sf);
        term = 2048;
        expr = 2048;
        for (int k = 1; k < terms; k++) begin
            p    = fmul(term, x2, sf);
            term = clamp(-fmul(p, longint'(rk[k-1]), sf), sf);
            expr = clamp(expr + term, sf);
        end
        c = W'(expr);
        d = W'(fmul(vs, expr, sf));
        s = sf;
    endtask

    bit           m_busy [3];
    bit           m_done [3];
    bit           m_sat  [3];
    bit           p_sat  [3];
    logic [W-1:0] m_cos  [3];
    logic [W-1:0] m_dist [3];
    logic [W-1:0] p_cos  [3];
    logic [W-1:0] p_dist [3];
    int           m_cnt  [3];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_busy[i] = 1'b0; m_done[i] = 1'b0; m_sat[i] = 1'b0;
                m_cos[i] = '0; m_dist[i] = '0; m_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!m_busy[i]) begin
                    if (start === 1'b1) begin
                        ref_cos(tv[i], x_in, v_in, p_cos[i], p_dist[i], p_sat[i]);
                        m_busy[i] = 1'b1;
                        m_done[i] = 1'b0;
                        m_sat[i]  = 1'b0;
                        m_cnt[i]  = 2 * tv[i];
                    end
                end else begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        m_cos[i]  = p_cos[i];
                        m_dist[i] = p_dist[i];
                        m_sat[i]  = p_sat[i];
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("busy", i, W'(busy_w[i]), W'(m_busy[i]));
                chk("done", i, W'(done_w[i]), W'(m_done[i]));
                chk("cos_out", i, cos_w[i], m_cos[i]);
                chk("distance", i, dist_w[i], m_dist[i]);
                // sat mid-run is an intermediate accumulation; it is defined once idle.
                if (!m_busy[i]) chk("sat", i, W'(sat_w[i]), W'(m_sat[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_once(input logic [W-1:0] x, input logic [W-1:0] v);
        int lat  [3];
        bit seen [3];
        @(negedge clk);
        start = 1'b1; x_in = x; v_in = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin lat[i] = 0; seen[i] = 1'b0; end
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && done_w[i] === 1'b1) begin seen[i] = 1'b1; lat[i] = e; end
            end
            if (seen[0] && seen[1] && seen[2]) break;
        end
        for (int i = 0; i < 3; i++) begin
            if (!seen[i]) begin
                n_vec++; n_err++;
                $display("FAIL latency[dut%0d]: done not seen within 40 edges, expected edge %0d",
                         i, 2 * tv[i]);
            end else begin
                chk("latency", i, W'(lat[i]), W'(2 * tv[i]));
            end
        end
    endtask

    task automatic chk_lit(input int i, input logic [W-1:0] c, input logic [W-1:0] d, input bit s);
        chk("lit_cos", i, cos_w[i], c);
        chk("lit_dist", i, dist_w[i], d);
        chk("lit_sat", i, W'(sat_w[i]), W'(s));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] c, d;
        bit s;
        int last;

        reset_n = 1'b0; start = 1'b0; x_in = '0; v_in = '0;

        // Pin the model to hand-computed values.
        ref_cos(4, 16'h0000, 16'h1800, c, d, s);
        chk("model_t1_cos", 1, c, 16'h0800); chk("model_t1_dist", 1, d, 16'h1800);
        ref_cos(4, 16'h0800, 16'h1000, c, d, s);
        chk("model_t2_cos", 1, c, 16'h0454); chk("model_t2_dist", 1, d, 16'h08A8);
        chk("model_t2_sat", 1, W'(s), 16'h0000);
        ref_cos(4, 16'h2000, 16'h1000, c, d, s);
        chk("model_t3_sat", 1, W'(s), 16'h0001);
        ref_cos(1, 16'h0800, 16'h1000, c, d, s);
        chk("model_t6_cos", 0, c, 16'h0800); chk("model_t6_dist", 0, d, 16'h1000);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_lit(i, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) chk("reset_busy", i, W'(busy_w[i]), 16'h0000);
        chk_en  = 1'b1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Case 1 and 2, case 6 rides on dut_t1/dut_t8.
        run_once(16'h0000, 16'h1800);
        chk_lit(1, 16'h0800, 16'h1800, 1'b0);
        run_once(16'h0800, 16'h1000);
        chk_lit(1, 16'h0454, 16'h08A8, 1'b0);
        chk_lit(0, 16'h0800, 16'h1000, 1'b0);
        run_once(16'h2000, 16'h1000);
        chk("lit_sat_clamp", 1, W'(sat_w[1]), 16'h0001);

        // Case 4: mid-run start then asynchronous reset.
        @(negedge clk);
        start = 1'b1; x_in = 16'h0800; v_in = 16'h1000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_busy", 1, W'(busy_w[1]), 16'h0001);
        chk("midrun_done", 1, W'(done_w[1]), 16'h0000);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_lit(i, 16'h0000, 16'h0000, 1'b0);
            chk("async_busy", i, W'(busy_w[i]), 16'h0000);
            chk("async_done", i, W'(done_w[i]), 16'h0000);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 1, W'(done_w[1]), 16'h0000);
        run_once(16'h0800, 16'h1000);
        chk_lit(1, 16'h0454, 16'h08A8, 1'b0);

        // Case 5: start held high, back-to-back runs.
        @(negedge clk);
        start = 1'b1; x_in = 16'h0800; v_in = 16'h1000;
        last = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done_w[1] === 1'b1) begin
                if (last >= 0) chk("done_period", 1, W'(cyc - last), 16'd9);
                last = cyc;
            end
        end
        chk("saw_done_b2b", 1, W'(last >= 0), 16'h0001);
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Randomized runs.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] rx, rv;
            if ($urandom_range(0, 1) == 0) rx = W'($urandom_range(0, 65535));
            else begin
                rx = W'($urandom_range(0, 7168));
                if ($urandom_range(0, 1) == 1) rx = W'(-rx);
            end
            rv = W'($urandom_range(0, 65535));
            run_once(rx, rv);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
